grid_scanner: RTL and testbench

Parametrised raster walker over the board's cell grid. Replaces the fixed 256-cell address counter and the combinational address/position/pixel helpers with one registered block. It emits one cell per valid/ready beat: linear address, grid X/Y, and top-left pixel X/Y. It sits between the game-state BRAM read side and the cell drawer, and signals the end of each pass with a single-cycle `done_all`.

---
 rtl/grid_scanner.sv | 252 +++++++++++++++++++++++++
 tb/tb_grid_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scanner.sv
// grid_scanner: registered raster walker over the board's cell grid.
// Presents one cell per valid/ready beat as a linear address, grid X/Y and
// top-left pixel X/Y. Pulses done_all for one cycle when the last cell is
// accepted.
// Optional feature: define GRID_SCANNER_WINDOW_EN to add the win_* ports. These
// restrict the pass to a rectangular window that is latched on start.
module grid_scanner #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 16,
    parameter int unsigned CELL_W   = 20,
    parameter int unsigned SPACING  = 5,
    parameter int unsigned ORIGIN_X = 0,
    parameter int unsigned ORIGIN_Y = 0,
    parameter int unsigned POS_W    = 4,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned PIX_W    = 11
) (
    input  logic              clock,
    input  logic              reset,
`ifdef GRID_SCANNER_WINDOW_EN
    input  logic [POS_W-1:0]  win_x0,
    input  logic [POS_W-1:0]  win_y0,
    input  logic [POS_W-1:0]  win_x1,
    input  logic [POS_W-1:0]  win_y1,
`endif
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] address,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic [PIX_W-1:0]  pix_x,
    output logic [PIX_W-1:0]  pix_y,
    output logic              busy,
    output logic              done_all
);

    localparam int unsigned      PITCH  = CELL_W + SPACING;
    localparam logic [POS_W-1:0] X_LAST = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(ROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched scan bounds for the current pass
    logic [POS_W-1:0] xmin_q, xmin_d;
    logic [POS_W-1:0] ymin_q, ymin_d;
    logic [POS_W-1:0] xmax_q, xmax_d;
    logic [POS_W-1:0] ymax_q, ymax_d;

    // Registered cell outputs; all of them move together on a load
    logic [POS_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_W-1:0]  pos_y_q, pos_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  pix_x_q, pix_x_d;
    logic [PIX_W-1:0]  pix_y_q, pix_y_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Candidate bounds presented at start time
    logic [POS_W-1:0] bnd_x0, bnd_y0, bnd_x1, bnd_y1;
    logic             bnd_empty;

    logic             beat;
    logic             last_cell;
    logic             load;
    logic [POS_W-1:0] nxt_x, nxt_y;

    // Linear address, truncated to the port width
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [POS_W-1:0] x,
                                                    input logic [POS_W-1:0] y);
        logic [31:0] lin;
        lin = 32'(y) * COLS + 32'(x);
        return lin[ADDR_W-1:0];
    endfunction

    // Top-left pixel coordinate of a cell along one axis
    function automatic logic [PIX_W-1:0] cell_pix(input logic [POS_W-1:0] p,
                                                  input int unsigned     org);
        logic [31:0] v;
        v = org + 32'(p) * PITCH;
        return v[PIX_W-1:0];
    endfunction

`ifdef GRID_SCANNER_WINDOW_EN
    // Window bounds from the ports; the far corner is clamped into the grid
    always_comb begin
        bnd_x0 = win_x0;
        bnd_y0 = win_y0;
        bnd_x1 = (win_x1 > X_LAST) ? X_LAST : win_x1;
        bnd_y1 = (win_y1 > Y_LAST) ? Y_LAST : win_y1;
    end
`else
    // Whole grid
    always_comb begin
        bnd_x0 = '0;
        bnd_y0 = '0;
        bnd_x1 = X_LAST;
        bnd_y1 = Y_LAST;
    end
`endif

    assign bnd_empty = (bnd_x0 > bnd_x1) || (bnd_y0 > bnd_y1);
    assign beat      = valid_q & ready;
    assign last_cell = (pos_x_q == xmax_q) && (pos_y_q == ymax_q);

    // Next-state and next-output computation for the walker
    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        ymin_d  = ymin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        addr_d  = addr_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        nxt_x   = pos_x_q;
        nxt_y   = pos_y_q;

        case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    xmin_d = bnd_x0;
                    ymin_d = bnd_y0;
                    xmax_d = bnd_x1;
                    ymax_d = bnd_y1;
                    busy_d = 1'b1;
                    if (bnd_empty) begin
                        // Nothing to scan: report completion with no beats
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StScan;
                        valid_d = 1'b1;
                        load    = 1'b1;
                        nxt_x   = bnd_x0;
                        nxt_y   = bnd_y0;
                    end
                end
            end
            StScan: begin
                if (abort) begin
                    // Abort beats a simultaneous beat; the pass is dropped
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (beat) begin
                    if (last_cell) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (pos_x_q == xmax_q) begin
                            nxt_x = xmin_q;
                            nxt_y = pos_y_q + POS_W'(1);
                        end else begin
                            nxt_x = pos_x_q + POS_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Derived outputs are computed from the next position so that they
        // register on the same edge as the position itself
        if (load) begin
            pos_x_d = nxt_x;
            pos_y_d = nxt_y;
            addr_d  = cell_addr(nxt_x, nxt_y);
            pix_x_d = cell_pix(nxt_x, ORIGIN_X);
            pix_y_d = cell_pix(nxt_y, ORIGIN_Y);
        end
    end

    // State and output registers; reset clears every output asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            xmin_q  <= '0;
            ymin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            addr_q  <= '0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            ymin_q  <= ymin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            addr_q  <= addr_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid    = valid_q;
    assign address  = addr_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign pix_x    = pix_x_q;
    assign pix_y    = pix_y_q;
    assign busy     = busy_q;
    assign done_all = done_q;

    // Output relationships that must always hold
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(valid_q && done_q)) else $error("valid and done_all together");
            assert (!valid_q || busy_q) else $error("valid without busy");
            assert (!done_q || busy_q) else $error("done_all without busy");
        end
    end

endmodule

// File: tb/tb_grid_scanner.sv
// tb_grid_scanner: randomized scoreboard bench for grid_scanner.
// The expected cell list of every pass is built from the raster rules. A
// negedge monitor compares each presented cell with the head of the queue and
// pops it on a beat.
module tb_grid_scanner;

    localparam int unsigned COLS   = 16;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned PITCH  = 25;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned PIX_W  = 11;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              ready = 1'b0;
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [POS_W-1:0]  pos_x, pos_y;
    logic [PIX_W-1:0]  pix_x, pix_y;
    logic              busy, done_all;
`ifdef GRID_SCANNER_WINDOW_EN
    logic [POS_W-1:0]  win_x0 = '0, win_y0 = '0, win_x1 = '0, win_y1 = '0;
`endif

    grid_scanner dut (
        .clock    (clock),
        .reset    (reset),
`ifdef GRID_SCANNER_WINDOW_EN
        .win_x0   (win_x0),
        .win_y0   (win_y0),
        .win_x1   (win_x1),
        .win_y1   (win_y1),
`endif
        .start    (start),
        .abort    (abort),
        .ready    (ready),
        .valid    (valid),
        .address  (address),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .busy     (busy),
        .done_all (done_all)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [POS_W-1:0]  x;
        logic [POS_W-1:0]  y;
        logic [PIX_W-1:0]  px;
        logic [PIX_W-1:0]  py;
    } cell_t;

    cell_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    cyc      = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the cells of one pass in raster order
    task automatic push_pass(input int x0, input int y0, input int x1, input int y1);
        int cx1, cy1;
        cx1 = (x1 > int'(COLS) - 1) ? int'(COLS) - 1 : x1;
        cy1 = (y1 > int'(ROWS) - 1) ? int'(ROWS) - 1 : y1;
        for (int y = y0; y <= cy1; y++) begin
            for (int x = x0; x <= cx1; x++) begin
                cell_t c;
                c.a  = ADDR_W'(y * int'(COLS) + x);
                c.x  = POS_W'(x);
                c.y  = POS_W'(y);
                c.px = PIX_W'(x * int'(PITCH));
                c.py = PIX_W'(y * int'(PITCH));
                exp_q.push_back(c);
            end
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare presented cells against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    cell_t e;
                    e = exp_q[0];
                    chk("address", address, e.a);
                    chk("pos_x", pos_x, e.x);
                    chk("pos_y", pos_y, e.y);
                    chk("pix_x", pix_x, e.px);
                    chk("pix_y", pix_y, e.py);
                    chk("busy_in_scan", busy, 1);
                    if (ready && !abort) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            if (done_all) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_cells_left", exp_q.size(), 0);
                chk("done_busy", busy, 1);
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done_all, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_pos"}, {pos_x, pos_y}, 0);
        chk({tag, "_pix"}, {pix_x, pix_y}, 0);
    endtask

    // Run one pass to done_all; rnd selects 30% ready plus stray start pulses
    task automatic run_pass(input int rnd, input int exp_beats, input int exp_lat);
        int b0, d0, st, n;
        b0 = beats;
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b1;
        ready = (rnd != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
        st    = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        n     = 0;
        while (done_cnt == d0 && n < 5000) begin
            ready = (rnd != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
            start = (rnd != 0) && busy && (done_all || $urandom_range(0, 7) == 0);
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        chk("pass_done_seen", done_cnt - d0, 1);
        chk("pass_beats", beats - b0, exp_beats);
        if (exp_lat >= 0) chk("done_latency", done_cyc - st, exp_lat);
        chk("idle_busy_low", busy, 0);
        chk("idle_done_low", done_all, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("single_done_pulse", done_cnt - d0, 1);
    endtask

    initial begin
        int b0, d0, n;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clock);
        chk("idle_no_valid", valid, 0);

        // Full pass, ready held high; done_all lands 257 cycles after start
        push_pass(0, 0, 15, 15);
        run_pass(0, 256, 257);

        // Random backpressure with stray start pulses in SCAN and DONE
        push_pass(0, 0, 15, 15);
        run_pass(1, 256, -1);

        // Abort coincident with a ready beat after 40 cells
        push_pass(0, 0, 15, 15);
        b0 = beats;
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (beats - b0 < 40 && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("abort_reached_beat40", beats - b0, 40);
        chk("abort_presented_addr", address, 40);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        exp_q.delete();
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done_all, 0);
        repeat (4) @(posedge clock);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        push_pass(0, 0, 15, 15);
        run_pass(0, 256, 257);

        // Asynchronous reset in the middle of a scan
        push_pass(0, 0, 15, 15);
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_idle_valid", valid, 0);
        push_pass(0, 0, 15, 15);
        run_pass(1, 256, -1);

`ifdef GRID_SCANNER_WINDOW_EN
        // Window (2,3)-(4,4): addresses 50,51,52,66,67,68
        win_x0 = 4'd2; win_y0 = 4'd3; win_x1 = 4'd4; win_y1 = 4'd4;
        push_pass(2, 3, 4, 4);
        run_pass(0, 6, -1);
        // Empty window: done_all right after start, no beats
        win_x0 = 4'd5; win_y0 = 4'd0; win_x1 = 4'd3; win_y1 = 4'd0;
        run_pass(0, 0, 1);
        // Window reaching the right edge
        win_x0 = 4'd13; win_y0 = 4'd0; win_x1 = 4'd15; win_y1 = 4'd1;
        push_pass(13, 0, 15, 1);
        run_pass(1, 6, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
